// File: rtl/mcs4_pkg.sv
// MCS-4 bus-cycle encodings shared by the host fetch sequencer and the i4001/i4002/i4003 blocks.
// State numbering follows the order of the eight bus windows in one instruction cycle.
package mcs4_pkg;

  typedef logic [2:0] state_t;

  localparam state_t A1 = 3'd0;
  localparam state_t A2 = 3'd1;
  localparam state_t A3 = 3'd2;
  localparam state_t M1 = 3'd3;
  localparam state_t M2 = 3'd4;
  localparam state_t X1 = 3'd5;
  localparam state_t X2 = 3'd6;
  localparam state_t X3 = 3'd7;

  typedef enum logic [1:0] {
    SLOT_PHI1 = 2'd0,
    SLOT_GAP1 = 2'd1,
    SLOT_PHI2 = 2'd2,
    SLOT_GAP2 = 2'd3
  } slot_e;

  function automatic logic is_addr_state(input state_t st);
    return (st == A1) || (st == A2) || (st == A3);
  endfunction

  // Address nibble placed on the bus in each address window, low nibble first.
  function automatic logic [3:0] addr_nibble(input logic [11:0] addr, input state_t st);
    logic [3:0] nib;
    nib = 4'h0;
    case (st)
      A1:      nib = addr[3:0];
      A2:      nib = addr[7:4];
      A3:      nib = addr[11:8];
      default: nib = 4'h0;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/mcs4_phase_gen.sv
// Two-phase bus clock generator: divider, slot and state counters plus the strobes that
// mark the clk edge opening a bus window and the clk edge on which PHI2 rises.
module mcs4_phase_gen
  import mcs4_pkg::*;
#(
  parameter int PHASE_DIV = 2
) (
  input  logic   clk_i,
  input  logic   rst,
  output logic   phi1,
  output logic   phi2,
  output state_t state,
  output logic   win_edge,
  output state_t win_state,
  output logic   phi2_edge
);

  localparam int DW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;

  logic [DW-1:0] div;
  logic          wrap;
  slot_e         slot;
  slot_e         slot_nxt;
  state_t        state_nxt;

  assign wrap = (div == DW'(PHASE_DIV - 1));

  always_comb begin
    slot_nxt  = slot;
    state_nxt = state;
    if (wrap) begin
      slot_nxt = slot_e'(slot + 2'd1);
      if (slot == SLOT_GAP2) state_nxt = state + 3'd1;
    end
  end

  // A window opens as the counters enter slot 3 and belongs to the following state.
  assign win_edge  = wrap && (slot == SLOT_PHI2);
  assign win_state = state + 3'd1;
  assign phi2_edge = wrap && (slot == SLOT_GAP1);

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      div   <= '0;
      slot  <= SLOT_PHI1;
      state <= X3;
      phi1  <= 1'b0;
      phi2  <= 1'b0;
    end else begin
      div   <= wrap ? '0 : div + DW'(1);
      slot  <= slot_nxt;
      state <= state_nxt;
      phi1  <= (slot_nxt == SLOT_PHI1);
      phi2  <= (slot_nxt == SLOT_PHI2);
    end
  end

endmodule

// File: rtl/mcs4_fetch_sequencer.sv
// Host-side MCS-4 bus master: accepts 12-bit fetch requests, drives the address nibbles,
// strobes CM in A3 and returns the opcode byte read back from the ROMs in M1/M2.
module mcs4_fetch_sequencer
  import mcs4_pkg::*;
#(
  parameter int PHASE_DIV = 2
) (
  input  logic        clk_i,
  input  logic        RESET_i,
  input  logic        req_i,
  input  logic [11:0] addr_i,
  output logic        ack_o,
  output logic [7:0]  rdata_o,
  output logic        rvalid_o,
  output logic        PHI1_o,
  output logic        PHI2_o,
  output logic        SYNC_o,
  output logic        CM_o,
  output logic [3:0]  d_o,
  output logic        d_oe_o,
  input  logic [3:0]  d_i
);

  state_t state;
  state_t win_state;
  logic   win_edge;
  logic   phi2_edge;

  mcs4_phase_gen #(
    .PHASE_DIV(PHASE_DIV)
  ) u_phase (
    .clk_i     (clk_i),
    .rst       (RESET_i),
    .phi1      (PHI1_o),
    .phi2      (PHI2_o),
    .state     (state),
    .win_edge  (win_edge),
    .win_state (win_state),
    .phi2_edge (phi2_edge)
  );

  logic        active_q;
  logic [11:0] addr_q;
  logic        cycle_start;
  logic        active_nxt;
  logic [11:0] drive_addr;
  logic        sync_nxt;
  logic        oe_nxt;
  logic        cm_nxt;
  logic [3:0]  d_nxt;

  // The A1 nibble leaves on the same edge that latches addr_i, so it comes from the port.
  always_comb begin
    cycle_start = win_edge && (win_state == A1);
    active_nxt  = cycle_start ? req_i : active_q;
    drive_addr  = cycle_start ? addr_i : addr_q;
    sync_nxt    = (win_state == A1);
    oe_nxt      = active_nxt && is_addr_state(win_state);
    cm_nxt      = active_nxt && (win_state == A3);
    d_nxt       = oe_nxt ? addr_nibble(drive_addr, win_state) : 4'h0;
  end

  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      active_q <= 1'b0;
      addr_q   <= '0;
      ack_o    <= 1'b0;
      SYNC_o   <= 1'b0;
      CM_o     <= 1'b0;
      d_oe_o   <= 1'b0;
      d_o      <= '0;
    end else begin
      ack_o <= cycle_start && req_i;
      if (cycle_start && req_i) addr_q <= addr_i;
      if (win_edge) begin
        active_q <= active_nxt;
        SYNC_o   <= sync_nxt;
        CM_o     <= cm_nxt;
        d_oe_o   <= oe_nxt;
        d_o      <= d_nxt;
      end
    end
  end

  // Stage p0: opcode nibbles captured on the PHI2 rising edge of M1 and M2.
  logic [3:0] cap_hi_p0;
  logic [3:0] cap_lo_p0;
  logic       vld_p0;

  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      cap_hi_p0 <= '0;
      cap_lo_p0 <= '0;
      vld_p0    <= 1'b0;
    end else begin
      vld_p0 <= phi2_edge && active_q && (state == M2);
      if (phi2_edge && active_q && (state == M1)) cap_hi_p0 <= d_i;
      if (phi2_edge && active_q && (state == M2)) cap_lo_p0 <= d_i;
    end
  end

  // Output stage: rdata_o only moves together with rvalid_o.
  always_ff @(posedge clk_i or posedge RESET_i) begin
    if (RESET_i) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= vld_p0;
      if (vld_p0) rdata_o <= {cap_hi_p0, cap_lo_p0};
    end
  end

endmodule

// File: tb/tb_mcs4_fetch_sequencer.sv
// Bench for mcs4_fetch_sequencer: two instances (PHASE_DIV 2 and 1), each with a behavioural
// chip-0 ROM on its D bus, driven by directed and randomized fetches.
module tb_mcs4_fetch_sequencer;

  localparam int PD0 = 2;
  localparam int PD1 = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req   [2];
  logic [11:0] addr  [2];
  logic        ack   [2];
  logic [7:0]  rdata [2];
  logic        rvalid[2];
  logic        phi1  [2];
  logic        phi2  [2];
  logic        sync  [2];
  logic        cm    [2];
  logic [3:0]  dout  [2];
  logic        doe   [2];
  logic [3:0]  din   [2] = '{4'hF, 4'hF};

  mcs4_fetch_sequencer #(.PHASE_DIV(PD0)) dut0 (
    .clk_i(clk), .RESET_i(rst), .req_i(req[0]), .addr_i(addr[0]), .ack_o(ack[0]),
    .rdata_o(rdata[0]), .rvalid_o(rvalid[0]), .PHI1_o(phi1[0]), .PHI2_o(phi2[0]),
    .SYNC_o(sync[0]), .CM_o(cm[0]), .d_o(dout[0]), .d_oe_o(doe[0]), .d_i(din[0])
  );

  mcs4_fetch_sequencer #(.PHASE_DIV(PD1)) dut1 (
    .clk_i(clk), .RESET_i(rst), .req_i(req[1]), .addr_i(addr[1]), .ack_o(ack[1]),
    .rdata_o(rdata[1]), .rvalid_o(rvalid[1]), .PHI1_o(phi1[1]), .PHI2_o(phi2[1]),
    .SYNC_o(sync[1]), .CM_o(cm[1]), .d_o(dout[1]), .d_oe_o(doe[1]), .d_i(din[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ROM (chip 0 only) and bus observer.
  logic [7:0]  rom [256];
  int          ack_t[2][$];
  int          rv_t [2][$];
  logic [7:0]  rv_d [2][$];
  int          widx [2] = '{7, 7};
  logic        phi2_q[2] = '{1'b0, 1'b0};
  logic [11:0] lat  [2];
  logic        oe_a [2];
  logic        cm_a3[2];
  logic        oe_m [2];
  logic        sel  [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (ack[i]) ack_t[i].push_back(cyc);
      if (rvalid[i]) begin
        rv_t[i].push_back(cyc);
        rv_d[i].push_back(rdata[i]);
      end
      if (phi2[i] && !phi2_q[i]) begin
        widx[i] = sync[i] ? 0 : widx[i] + 1;
        case (widx[i])
          0: begin lat[i][3:0] = dout[i]; oe_a[i] = doe[i]; cm_a3[i] = 1'b0; oe_m[i] = 1'b0; end
          1: begin lat[i][7:4] = dout[i]; oe_a[i] = oe_a[i] & doe[i]; end
          2: begin
            lat[i][11:8] = dout[i];
            oe_a[i]  = oe_a[i] & doe[i];
            cm_a3[i] = cm[i];
            sel[i]   = doe[i] && cm[i] && (dout[i] == 4'h0);
            din[i]   = sel[i] ? rom[lat[i][7:0]][7:4] : 4'hF;
          end
          3: begin oe_m[i] = doe[i]; din[i] = sel[i] ? rom[lat[i][7:0]][3:0] : 4'hF; end
          4: begin oe_m[i] = oe_m[i] | doe[i]; din[i] = 4'hF; end
          default: ;
        endcase
      end
      phi2_q[i] = phi2[i];
    end
  end

  task automatic wait_acks(input int i, input int n, input int budget);
    int b;
    b = 0;
    while (ack_t[i].size() < n && b < budget) begin @(negedge clk); #1; b++; end
  endtask

  task automatic wait_rvs(input int i, input int n, input int budget);
    int b;
    b = 0;
    while (rv_t[i].size() < n && b < budget) begin @(negedge clk); #1; b++; end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input int i, input string tag);
    chk(tag, {ack[i], rvalid[i], rdata[i], phi1[i], phi2[i], sync[i], cm[i], dout[i], doe[i]}, 32'h0);
  endtask

  task automatic do_fetch(input int i, input logic [11:0] a, input logic [7:0] exp, input string tag);
    int n0, r0, pd;
    n0 = ack_t[i].size();
    r0 = rv_t[i].size();
    pd = (i == 0) ? PD0 : PD1;
    addr[i] = a;
    req[i]  = 1'b1;
    wait_acks(i, n0 + 1, 400);
    req[i] = 1'b0;
    chk({tag, "_ack"}, ack_t[i].size(), n0 + 1);
    wait_rvs(i, r0 + 1, 400);
    chk({tag, "_rvalid"}, rv_t[i].size(), r0 + 1);
    if (rv_t[i].size() > r0 && ack_t[i].size() > n0) begin
      chk({tag, "_rdata"}, rv_d[i][r0], exp);
      chk({tag, "_latency"}, rv_t[i][r0] - ack_t[i][n0], 19 * pd + 1);
      chk({tag, "_addr_nibbles"}, lat[i], a);
      chk({tag, "_oe_addr"}, oe_a[i], 1'b1);
      chk({tag, "_cm_a3"}, cm_a3[i], 1'b1);
      chk({tag, "_oe_mem"}, oe_m[i], 1'b0);
    end
  endtask

  task automatic back_to_back(input int i, input logic [11:0] a0, input logic [11:0] a1, input string tag);
    int n0, r0, pd;
    n0 = ack_t[i].size();
    r0 = rv_t[i].size();
    pd = (i == 0) ? PD0 : PD1;
    addr[i] = a0;
    req[i]  = 1'b1;
    wait_acks(i, n0 + 1, 400);
    addr[i] = a1;
    wait_acks(i, n0 + 2, 400);
    req[i] = 1'b0;
    chk({tag, "_acks"}, ack_t[i].size(), n0 + 2);
    if (ack_t[i].size() >= n0 + 2)
      chk({tag, "_ack_gap"}, ack_t[i][n0 + 1] - ack_t[i][n0], 32 * pd);
    wait_rvs(i, r0 + 2, 400);
    chk({tag, "_rvalids"}, rv_t[i].size(), r0 + 2);
    if (rv_t[i].size() >= r0 + 2) begin
      chk({tag, "_rv_gap"}, rv_t[i][r0 + 1] - rv_t[i][r0], 32 * pd);
      chk({tag, "_data0"}, rv_d[i][r0], rom[a0[7:0]]);
      chk({tag, "_data1"}, rv_d[i][r0 + 1], rom[a1[7:0]]);
    end
  endtask

  task automatic idle_check();
    int s0, s1, p1a, p1b, p2a, p2b, bad, run, maxrun;
    s0 = 0; s1 = 0; p1a = 0; p1b = 0; p2a = 0; p2b = 0; bad = 0; run = 0; maxrun = 0;
    for (int t = 0; t < 128; t++) begin
      @(negedge clk); #1;
      if (sync[0]) s0++;
      if (sync[1]) s1++;
      if (phi1[0]) p1a++;
      if (phi1[1]) p1b++;
      if (phi2[0]) p2a++;
      if (phi2[1]) p2b++;
      if ((phi1[0] && phi2[0]) || (phi1[1] && phi2[1])) bad++;
      if (doe[0] || cm[0] || doe[1] || cm[1]) bad++;
      if (sync[0]) begin run++; if (run > maxrun) maxrun = run; end else run = 0;
    end
    chk("idle_sync_pd2", s0, 16);
    chk("idle_sync_run_pd2", maxrun, 8);
    chk("idle_phi1_pd2", p1a, 32);
    chk("idle_phi2_pd2", p2a, 32);
    chk("idle_sync_pd1", s1, 16);
    chk("idle_phi1_pd1", p1b, 32);
    chk("idle_phi2_pd1", p2b, 32);
    chk("idle_bus_quiet", bad, 0);
    chk("idle_no_ack", ack_t[0].size() + ack_t[1].size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0d cycles, expected to finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, r, n_ack, n_rv;
    logic [11:0] a;
    logic [7:0]  e;

    for (int j = 0; j < 256; j++) rom[j] = 8'($urandom);
    rom[8'hA5] = 8'h3C;
    req  = '{1'b0, 1'b0};
    addr = '{12'h0, 12'h0};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs(0, "reset_pd2");
    chk_reset_outputs(1, "reset_pd1");
    rst = 1'b0;

    repeat (64) @(negedge clk);
    idle_check();

    do_fetch(0, 12'h0A5, 8'h3C, "fetch_0a5");
    back_to_back(0, 12'h010, 12'h011, "b2b_pd2");
    do_fetch(0, 12'h3A5, 8'hFF, "float_3a5");

    // Request raised and dropped between two cycle starts must be ignored.
    k = ack_t[0][$];
    n_ack = ack_t[0].size();
    wait_until(k + 45);
    addr[0] = 12'h0A5;
    req[0]  = 1'b1;
    wait_until(k + 60);
    req[0] = 1'b0;
    wait_until(k + 160);
    chk("dropped_req_no_ack", ack_t[0].size(), n_ack);

    for (int n = 0; n < 6; n++) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      a[11:8] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      a[7:0]  = 8'($urandom);
      e = (a[11:8] == 4'h0) ? rom[a[7:0]] : 8'hFF;
      do_fetch(0, a, e, "rand_pd2");
    end

    // Reset in the middle of M1 of an active fetch.
    n_ack = ack_t[0].size();
    addr[0] = 12'h0A5;
    req[0]  = 1'b1;
    wait_acks(0, n_ack + 1, 400);
    chk("abort_first_ack", ack_t[0].size(), n_ack + 1);
    k = ack_t[0][$];
    wait_until(k + 28);
    n_rv = rv_t[0].size();
    rst = 1'b1;
    #1;
    chk_reset_outputs(0, "abort_outputs_zero");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    r = cyc;
    n_ack = ack_t[0].size();
    wait_acks(0, n_ack + 1, 400);
    req[0] = 1'b0;
    chk("abort_reack", ack_t[0].size(), n_ack + 1);
    if (ack_t[0].size() > n_ack) begin
      chk("abort_reack_time", ack_t[0][n_ack] - r, 3 * PD0);
      wait_rvs(0, n_rv + 1, 400);
      chk("abort_rvalid", rv_t[0].size(), n_rv + 1);
      if (rv_t[0].size() > n_rv) begin
        chk("abort_no_stale_rvalid", rv_t[0][n_rv] - ack_t[0][n_ack], 19 * PD0 + 1);
        chk("abort_refetch_data", rv_d[0][n_rv], 8'h3C);
      end
    end

    do_fetch(1, 12'h0A5, 8'h3C, "fetch_pd1");
    back_to_back(1, 12'h010, 12'h011, "b2b_pd1");
    a = {4'h0, 8'($urandom)};
    do_fetch(1, a, rom[a[7:0]], "rand_pd1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
